sobel_grad_pipe: RTL and testbench

Parametrised, streaming Sobel gradient engine that computes both Gx and Gy from a 3x3 pixel window and reduces them to a selectable output pixel: |Gx|, |Gy|, |Gx|+|Gy| or a thresholded edge map. It sits between the line-buffer/window generator and the feature-map writer in the CNN accelerator datapath. It is a 3-stage pipeline with valid/ready flow control on both sides, per-frame mode latching and saturation accounting.

---
 rtl/sobel_grad_pipe_if.sv | 31 +++
 rtl/sobel_grad_pipe.sv | 169 ++++++++++++++++
 tb/tb_sobel_grad_pipe.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sobel_grad_pipe_if.sv
// Streaming window-in / pixel-out bundle for the Sobel gradient engine.
// master = the side that feeds windows and consumes results,
// slave  = the gradient engine itself.
interface sobel_grad_pipe_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
);
  logic                     in_valid;
  logic                     in_ready;
  logic                     in_sof;
  logic [9*DATA_W-1:0]      win;
  logic [1:0]               mode;
  logic [OUT_W-1:0]         threshold;
  logic                     out_valid;
  logic                     out_ready;
  logic                     out_sof;
  logic signed [DATA_W+2:0] gx;
  logic signed [DATA_W+2:0] gy;
  logic [OUT_W-1:0]         out_pix;
  logic [15:0]              sat_cnt;

  modport master (
    output in_valid, in_sof, win, mode, threshold, out_ready,
    input  in_ready, out_valid, out_sof, gx, gy, out_pix, sat_cnt
  );

  modport slave (
    input  in_valid, in_sof, win, mode, threshold, out_ready,
    output in_ready, out_valid, out_sof, gx, gy, out_pix, sat_cnt
  );
endinterface

// File: rtl/sobel_grad_pipe.sv
// 3-stage streaming Sobel engine: partial sums -> signed Gx/Gy -> reduced pixel.
// One global advance signal moves all stages together; bubbles keep their slot.
// Mode/threshold are latched on each accepted start-of-frame and travel with the beat.
module sobel_grad_pipe #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8
) (
  input logic              Clk,
  input logic              Rst,
  sobel_grad_pipe_if.slave bus
);
  localparam int SUM_W = DATA_W + 2;  // column sum of 1-2-1 weights, max 4*(2^DATA_W-1)
  localparam int G_W   = DATA_W + 3;  // signed difference of two sums
  localparam int MAG_W = DATA_W + 3;  // |gx|+|gy| <= 8*(2^DATA_W-1) still fits
  localparam logic [MAG_W-1:0] SAT_MAX = MAG_W'((1 << OUT_W) - 1);

  // column/row weighted sum a + 2b + c, never overflows SUM_W
  function automatic logic [SUM_W-1:0] f_wsum(input logic [DATA_W-1:0] a,
                                              input logic [DATA_W-1:0] b,
                                              input logic [DATA_W-1:0] c);
    return SUM_W'(a) + (SUM_W'(b) << 1) + SUM_W'(c);
  endfunction

  // clip a magnitude to the output pixel range
  function automatic logic [OUT_W-1:0] f_sat(input logic [MAG_W-1:0] x);
    return (x > SAT_MAX) ? {OUT_W{1'b1}} : x[OUT_W-1:0];
  endfunction

  logic [DATA_W-1:0] w_p [9];
  logic              w_advance;
  logic              w_accept;
  logic [1:0]        w_beat_mode;
  logic [OUT_W-1:0]  w_beat_thr;
  logic [MAG_W-1:0]  w_absx;
  logic [MAG_W-1:0]  w_absy;
  logic [MAG_W-1:0]  w_mag;
  logic [OUT_W-1:0]  w_pix;
  logic              w_clip;

  logic [1:0]        r_active_mode;
  logic [OUT_W-1:0]  r_active_thr;

  logic              r_v1, r_sof1;
  logic [1:0]        r_mode1;
  logic [OUT_W-1:0]  r_thr1;
  logic [SUM_W-1:0]  r_sa1, r_sb1, r_sc1, r_sd1;

  logic              r_v2, r_sof2;
  logic [1:0]        r_mode2;
  logic [OUT_W-1:0]  r_thr2;
  logic signed [G_W-1:0] r_gx2, r_gy2;

  logic              r_v3, r_sof3;
  logic [1:0]        r_mode3;
  logic signed [G_W-1:0] r_gx3, r_gy3;
  logic [MAG_W-1:0]  r_absx3, r_absy3, r_mag3;
  logic [OUT_W-1:0]  r_pix3;
  logic [15:0]       r_sat_cnt;

  genvar gi;
  generate
    for (gi = 0; gi < 9; gi++) begin : g_unpack
      assign w_p[gi] = bus.win[gi*DATA_W +: DATA_W];
    end
  endgenerate

  assign w_advance   = !r_v3 || bus.out_ready;
  assign w_accept    = bus.in_valid && w_advance;
  // a start-of-frame beat already uses its own mode, not the previous frame's
  assign w_beat_mode = bus.in_sof ? bus.mode      : r_active_mode;
  assign w_beat_thr  = bus.in_sof ? bus.threshold : r_active_thr;

  assign w_absx = r_gx2[G_W-1] ? MAG_W'(-r_gx2) : MAG_W'(r_gx2);
  assign w_absy = r_gy2[G_W-1] ? MAG_W'(-r_gy2) : MAG_W'(r_gy2);
  assign w_mag  = w_absx + w_absy;

  // reduce the stage-2 gradients to the output pixel for this beat's mode
  always_comb begin
    w_pix = '0;
    case (r_mode2)
      2'd0:    w_pix = f_sat(w_absx);
      2'd1:    w_pix = f_sat(w_absy);
      2'd2:    w_pix = f_sat(w_mag);
      default: w_pix = (f_sat(w_mag) >= r_thr2) ? {OUT_W{1'b1}} : '0;
    endcase
  end

  // did clipping change the delivered result (threshold mode never counts)
  always_comb begin
    w_clip = 1'b0;
    case (r_mode3)
      2'd0:    w_clip = (r_absx3 > SAT_MAX);
      2'd1:    w_clip = (r_absy3 > SAT_MAX);
      2'd2:    w_clip = (r_mag3 > SAT_MAX);
      default: w_clip = 1'b0;
    endcase
  end

  // latch mode/threshold on every accepted start-of-frame
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_active_mode <= '0;
      r_active_thr  <= '0;
    end else if (w_accept && bus.in_sof) begin
      r_active_mode <= bus.mode;
      r_active_thr  <= bus.threshold;
    end
  end

  // lock-step pipeline; data registers load only when a valid beat moves in
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_v1 <= 1'b0; r_sof1 <= 1'b0; r_mode1 <= '0; r_thr1 <= '0;
      r_sa1 <= '0; r_sb1 <= '0; r_sc1 <= '0; r_sd1 <= '0;
      r_v2 <= 1'b0; r_sof2 <= 1'b0; r_mode2 <= '0; r_thr2 <= '0;
      r_gx2 <= '0; r_gy2 <= '0;
      r_v3 <= 1'b0; r_sof3 <= 1'b0; r_mode3 <= '0;
      r_gx3 <= '0; r_gy3 <= '0;
      r_absx3 <= '0; r_absy3 <= '0; r_mag3 <= '0; r_pix3 <= '0;
    end else if (w_advance) begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_sof1  <= bus.in_sof;
        r_mode1 <= w_beat_mode;
        r_thr1  <= w_beat_thr;
        r_sa1   <= f_wsum(w_p[0], w_p[3], w_p[6]);  // left column
        r_sb1   <= f_wsum(w_p[2], w_p[5], w_p[8]);  // right column
        r_sc1   <= f_wsum(w_p[0], w_p[1], w_p[2]);  // top row
        r_sd1   <= f_wsum(w_p[6], w_p[7], w_p[8]);  // bottom row
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_sof2  <= r_sof1;
        r_mode2 <= r_mode1;
        r_thr2  <= r_thr1;
        r_gx2   <= $signed({1'b0, r_sa1}) - $signed({1'b0, r_sb1});
        r_gy2   <= $signed({1'b0, r_sc1}) - $signed({1'b0, r_sd1});
      end
      r_v3 <= r_v2;
      if (r_v2) begin
        r_sof3  <= r_sof2;
        r_mode3 <= r_mode2;
        r_gx3   <= r_gx2;
        r_gy3   <= r_gy2;
        r_absx3 <= w_absx;
        r_absy3 <= w_absy;
        r_mag3  <= w_mag;
        r_pix3  <= w_pix;
      end
    end
  end

  // count delivered results that were clipped, sticking at all-ones
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_sat_cnt <= '0;
    end else if (r_v3 && bus.out_ready && w_clip && (r_sat_cnt != 16'hFFFF)) begin
      r_sat_cnt <= r_sat_cnt + 16'd1;
    end
  end

  assign bus.in_ready  = w_advance;
  assign bus.out_valid = r_v3;
  assign bus.out_sof   = r_sof3;
  assign bus.gx        = r_gx3;
  assign bus.gy        = r_gy3;
  assign bus.out_pix   = r_pix3;
  assign bus.sat_cnt   = r_sat_cnt;
endmodule

// File: tb/tb_sobel_grad_pipe.sv
// Directed bench for sobel_grad_pipe: single beats with hand-computed results,
// a stalled 20-beat stream, and a mid-stream reset.
module tb_sobel_grad_pipe;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  sobel_grad_pipe_if #(.DATA_W(8), .OUT_W(8)) bus ();

  sobel_grad_pipe #(.DATA_W(8), .OUT_W(8)) dut (
    .Clk (clk),
    .Rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [71:0] mkwin(input logic [7:0] p0, input logic [7:0] p1,
                                       input logic [7:0] p2, input logic [7:0] p3,
                                       input logic [7:0] p4, input logic [7:0] p5,
                                       input logic [7:0] p6, input logic [7:0] p7,
                                       input logic [7:0] p8);
    return {p8, p7, p6, p5, p4, p3, p2, p1, p0};
  endfunction

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one beat into an empty pipe with out_ready high; checks latency and result
  task automatic run_beat(input string tag, input logic [71:0] w, input logic sof,
                          input logic [1:0] m, input logic [7:0] thr,
                          input int egx, input int egy, input int epix,
                          input int esof, input int esat);
    int lat;
    bus.win = w; bus.in_sof = sof; bus.mode = m; bus.threshold = thr;
    bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 10) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, ".latency"}, lat, 3);
    chk({tag, ".gx"}, $signed(bus.gx), egx);
    chk({tag, ".gy"}, $signed(bus.gy), egy);
    chk({tag, ".out_pix"}, bus.out_pix, epix);
    chk({tag, ".out_sof"}, bus.out_sof, esof);
    @(posedge clk); #1;
    chk({tag, ".sat_cnt"}, bus.sat_cnt, esat);
    chk({tag, ".drained"}, bus.out_valid, 0);
    $display("beat %s: gx=%0d gy=%0d pix=%0d sat_cnt=%0d", tag, egx, egy, epix, esat);
  endtask

  initial begin
    int sent, rcv, cyc, n_seen;
    logic stalled;
    logic signed [31:0] saved_gx, saved_pix;
    n_cmp = 0; n_fail = 0;
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.in_sof = 1'b0; bus.win = '0;
    bus.mode = 2'd0; bus.threshold = '0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    chk("reset.out_valid", bus.out_valid, 0);
    chk("reset.in_ready", bus.in_ready, 1);
    chk("reset.gx", $signed(bus.gx), 0);
    chk("reset.gy", $signed(bus.gy), 0);
    chk("reset.out_pix", bus.out_pix, 0);
    chk("reset.sat_cnt", bus.sat_cnt, 0);
    $display("reset released");

    // flat window, mode 0 (reset default)
    run_beat("flat100", mkwin(100,100,100,100,100,100,100,100,100), 1'b0, 2'd0, 8'd0,
             0, 0, 0, 0, 0);
    // left column 10, sof latches mode 0
    run_beat("col10", mkwin(10,0,0,10,0,0,10,0,0), 1'b1, 2'd0, 8'd0, 40, 0, 40, 1, 0);
    // top row 3, mode input 2 ignored mid-frame -> |gx| = 0
    run_beat("top3_m0", mkwin(3,3,3,0,0,0,0,0,0), 1'b0, 2'd2, 8'd0, 0, 12, 0, 0, 0);
    // left column 255, sof mode 2: magnitude 1020 clips
    run_beat("left255_m2", mkwin(255,0,0,255,0,0,255,0,0), 1'b1, 2'd2, 8'd0,
             1020, 0, 255, 1, 1);
    // mirrored, sof mode 0: negative gx clips by magnitude
    run_beat("right255_m0", mkwin(0,0,255,0,0,255,0,0,255), 1'b1, 2'd0, 8'd0,
             -1020, 0, 255, 1, 2);
    // mode 1
    run_beat("p1_50_m1", mkwin(0,50,0,0,0,0,0,0,0), 1'b1, 2'd1, 8'd0, 0, 100, 100, 1, 2);
    // mode 2 without clipping
    run_beat("p0_20_m2", mkwin(20,0,0,0,0,0,0,0,0), 1'b1, 2'd2, 8'd0, 20, 20, 40, 1, 2);
    // mode 3, threshold 12: magnitude 12 meets it exactly
    run_beat("top3_m3", mkwin(3,3,3,0,0,0,0,0,0), 1'b1, 2'd3, 8'd12, 0, 12, 255, 1, 2);
    // same frame, new threshold ignored: magnitude 8 < 12
    run_beat("top2_m3", mkwin(2,2,2,0,0,0,0,0,0), 1'b0, 2'd0, 8'd0, 0, 8, 0, 0, 2);
    // same frame, huge magnitude: edge, but threshold mode never counts clipping
    run_beat("left255_m3", mkwin(255,0,0,255,0,0,255,0,0), 1'b0, 2'd1, 8'd0,
             1020, 0, 255, 0, 2);

    // 20-beat stream with back-pressure, 5-cycle stall at cycles 6..10
    sent = 0; rcv = 0; cyc = 0;
    while (rcv < 20 && cyc < 300) begin
      bus.out_ready = (cyc >= 6 && cyc < 11) ? 1'b0 : ((cyc % 3) != 2);
      bus.in_valid  = (sent < 20);
      bus.win       = mkwin(8'(sent + 1), 0, 0, 0, 0, 0, 0, 0, 0);
      bus.in_sof    = (sent == 0);
      bus.mode      = (sent == 0) ? 2'd0 : 2'd1;
      bus.threshold = 8'd0;
      #1;
      chk("stream.in_ready", bus.in_ready, !(bus.out_valid && !bus.out_ready));
      if (bus.out_valid && bus.out_ready) begin
        chk("stream.gx", $signed(bus.gx), rcv + 1);
        chk("stream.gy", $signed(bus.gy), rcv + 1);
        chk("stream.out_pix", bus.out_pix, rcv + 1);
        $display("stream out %0d: gx=%0d pix=%0d", rcv, $signed(bus.gx), bus.out_pix);
        rcv++;
      end
      stalled   = bus.out_valid && !bus.out_ready;
      saved_gx  = $signed(bus.gx);
      saved_pix = bus.out_pix;
      if (bus.in_valid && bus.in_ready) sent++;
      @(posedge clk); #1;
      cyc++;
      if (stalled) begin
        chk("stall.out_valid", bus.out_valid, 1);
        chk("stall.gx_hold", $signed(bus.gx), saved_gx);
        chk("stall.pix_hold", bus.out_pix, saved_pix);
      end
    end
    chk("stream.count", rcv, 20);
    chk("stream.sat_cnt", bus.sat_cnt, 2);
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;

    // three beats in flight, the third presented while Rst is high
    bus.win = mkwin(0,50,0,0,0,0,0,0,0); bus.in_sof = 1'b1; bus.mode = 2'd1;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_sof = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    chk("midrst.in_ready", bus.in_ready, 1);
    chk("midrst.gx", $signed(bus.gx), 0);
    chk("midrst.gy", $signed(bus.gy), 0);
    chk("midrst.out_pix", bus.out_pix, 0);
    chk("midrst.out_sof", bus.out_sof, 0);
    chk("midrst.sat_cnt", bus.sat_cnt, 0);
    n_seen = 0;
    if (bus.out_valid) n_seen++;
    repeat (8) begin
      @(posedge clk); #1;
      if (bus.out_valid) n_seen++;
    end
    chk("midrst.no_valid", n_seen, 0);
    $display("mid-stream reset: valids seen afterwards=%0d", n_seen);
    // sof-less beat after reset uses mode 0: |gx| = 0, not |gy| = 100
    run_beat("post_rst", mkwin(0,50,0,0,0,0,0,0,0), 1'b0, 2'd1, 8'd0, 0, 100, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
